// File: rtl/seq_bit_entry_pkg.sv
// Shared types and constants for the push-button bit-entry front end.
package seq_entry_pkg;

   localparam int DB_CYCLES_DEF     = 1_000_000;   // 10 ms at 100 MHz
   localparam int REPEAT_CYCLES_DEF = 50_000_000;  // 0.5 s at 100 MHz
   localparam int DB_CYCLES_SIM     = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } entry_state_t;

   // Counter width that can hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_bit_entry_btn_debounce.sv
// One raw button: 2-FF synchronizer, stable-level debouncer and a
// one-cycle press strobe on the rising edge of the debounced level.
module btn_debounce
   import seq_entry_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic fsm_clk,
   input  logic clr,
   input  logic btn,
   output logic stable,
   output logic press
);

   localparam int CNT_W = cnt_width(DB_CYCLES);

   logic             sync1;
   logic             sync2;
   logic             stable_q;
   logic [CNT_W-1:0] db_cnt;

   // NOTE: every state bit here is a flop, so only non-blocking assignments;
   // blocking ones would let sync2 see this cycle's sync1 and collapse the chain.
   always_ff @(posedge fsm_clk) begin
      if (clr) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_q <= stable;
         // Any return to the stable level restarts the count from zero.
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
            stable <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   assign press = stable & ~stable_q;

endmodule

// File: rtl/seq_bit_entry.sv
// Two-button serial bit entry: press "one"/"zero" to emit din with a din_valid
// strobe. Define SEQ_AUTOREPEAT_EN to re-emit the bit while a single button is held.
module seq_bit_entry
   import seq_entry_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic       fsm_clk,
   input  logic       clr,
   input  logic       btn_one,
   input  logic       btn_zero,
   output logic       din,
   output logic       din_valid,
   output logic       both_err,
   output logic [7:0] entry_cnt
);

   if (DB_CYCLES < 2) begin : g_bad_db
      $error("DB_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 1");
   end

   logic         one_stable;
   logic         one_press;
   logic         zero_stable;
   logic         zero_press;
   entry_state_t state;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_one (
      .fsm_clk (fsm_clk),
      .clr     (clr),
      .btn     (btn_one),
      .stable  (one_stable),
      .press   (one_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_zero (
      .fsm_clk (fsm_clk),
      .clr     (clr),
      .btn     (btn_zero),
      .stable  (zero_stable),
      .press   (zero_press)
   );

`ifdef SEQ_AUTOREPEAT_EN
   localparam int REP_W = cnt_width(REPEAT_CYCLES);
   logic [REP_W-1:0] rep_cnt;
`endif

   always_ff @(posedge fsm_clk) begin
      if (clr) begin
         state     <= IDLE;
         din       <= 1'b0;
         din_valid <= 1'b0;
         both_err  <= 1'b0;
         entry_cnt <= '0;
`ifdef SEQ_AUTOREPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         din_valid <= 1'b0;
         both_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (one_press && zero_press) begin
                  both_err <= 1'b1;
                  state    <= HELD;
`ifdef SEQ_AUTOREPEAT_EN
                  rep_cnt  <= '0;
`endif
               end else if (one_press || zero_press) begin
                  din       <= one_press;
                  din_valid <= 1'b1;
                  entry_cnt <= entry_cnt + 8'd1;
                  state     <= HELD;
`ifdef SEQ_AUTOREPEAT_EN
                  rep_cnt   <= '0;
`endif
               end
            end
            HELD: begin
               // Any new press while a bit is held down is ambiguous and dropped.
               if (!one_stable && !zero_stable) begin
                  state <= IDLE;
               end else if (one_press || zero_press) begin
                  both_err <= 1'b1;
`ifdef SEQ_AUTOREPEAT_EN
                  rep_cnt  <= '0;
`endif
               end
`ifdef SEQ_AUTOREPEAT_EN
               else if (one_stable ^ zero_stable) begin
                  if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                     din_valid <= 1'b1;
                     entry_cnt <= entry_cnt + 8'd1;
                     rep_cnt   <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + REP_W'(1);
                  end
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bit_entry.sv
// Directed bench for seq_bit_entry with DB_CYCLES=4, REPEAT_CYCLES=10.
module tb_seq_bit_entry;
   import seq_entry_pkg::*;

   localparam int REP_SIM = 10;

   logic       fsm_clk = 1'b0;
   logic       clr;
   logic       btn_one;
   logic       btn_zero;
   logic       din;
   logic       din_valid;
   logic       both_err;
   logic [7:0] entry_cnt;

   seq_bit_entry #(
      .DB_CYCLES     (DB_CYCLES_SIM),
      .REPEAT_CYCLES (REP_SIM)
   ) dut (
      .fsm_clk   (fsm_clk),
      .clr       (clr),
      .btn_one   (btn_one),
      .btn_zero  (btn_zero),
      .din       (din),
      .din_valid (din_valid),
      .both_err  (both_err),
      .entry_cnt (entry_cnt)
   );

   always #5 fsm_clk = ~fsm_clk;

   typedef struct {
      logic       clr;
      logic       b1;
      logic       b0;
      logic       exp_valid;
      logic       exp_din;
      logic       exp_err;
      logic [7:0] exp_cnt;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   int   vectors     = 0;
   int   miscompares = 0;
   int   edge_no     = 0;
   int   din_glitch  = 0;
   logic din_prev    = 1'b0;
   int   strobe_edges [$];
   logic strobe_din   [$];
   int   err_edges    [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, sample outputs 1 ns later.
   task automatic step(input logic c, input logic b1, input logic b0);
      clr      = c;
      btn_one  = b1;
      btn_zero = b0;
      @(posedge fsm_clk);
      #1;
      edge_no++;
      if (din_valid === 1'b1) begin
         strobe_edges.push_back(edge_no);
         strobe_din.push_back(din);
      end
      if (both_err === 1'b1) err_edges.push_back(edge_no);
      if (c == 1'b0 && din !== din_prev && din_valid !== 1'b1) din_glitch++;
      din_prev = din;
   endtask

   task automatic mark();
      edge_no = 0;
      strobe_edges.delete();
      strobe_din.delete();
      err_edges.delete();
   endtask

   function automatic int edge_at(input int idx);
      return (idx < strobe_edges.size()) ? strobe_edges[idx] : -1;
   endfunction

   function automatic int err_at(input int idx);
      return (idx < err_edges.size()) ? err_edges[idx] : -1;
   endfunction

   function automatic vec_t mk(input logic c, b1, b0, v, d, e, input logic [7:0] n);
      vec_t r;
      r.clr = c; r.b1 = b1; r.b0 = b0;
      r.exp_valid = v; r.exp_din = d; r.exp_err = e; r.exp_cnt = n;
      return r;
   endfunction

   initial begin
      logic din_before;

      // Reset with both buttons active, one quiet cycle, clean press, release.
      for (int i = 0; i < 3; i++) vecs[i] = mk(1, 1, 1, 0, 0, 0, 8'd0);
      vecs[3] = mk(0, 0, 0, 0, 0, 0, 8'd0);
      for (int e = 1; e <= 10; e++)
         vecs[3 + e] = mk(0, 1, 0, (e == 7), (e >= 7), 0, (e >= 7) ? 8'd1 : 8'd0);
      for (int e = 1; e <= 10; e++)
         vecs[13 + e] = mk(0, 0, 0, 0, 1, 0, 8'd1);

      clr = 1'b1; btn_one = 1'b0; btn_zero = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].clr, vecs[i].b1, vecs[i].b0);
         check($sformatf("vec%0d {valid,din,err,cnt}", i),
               {21'd0, din_valid, din, both_err, entry_cnt},
               {21'd0, vecs[i].exp_valid, vecs[i].exp_din, vecs[i].exp_err, vecs[i].exp_cnt});
      end

      // Bounce on btn_zero: high 3, low 1, high 10; last rise sampled at edge 5.
      mark();
      din_before = 1'b0;
      for (int e = 1; e <= 24; e++) begin
         step(0, 0, (e <= 3) || (e >= 5 && e <= 14));
         if (e == 10) din_before = din;
      end
      check("bounce strobes", strobe_edges.size(), 1);
      check("bounce strobe edge", edge_at(0), 11);
      check("bounce din held before", din_before, 1);
      check("bounce din", din, 0);
      check("bounce cnt", entry_cnt, 2);

      // Same-cycle press, then btn_zero re-pressed while btn_one stays down.
      mark();
      for (int e = 1; e <= 10; e++) step(0, 1, 1);
      for (int e = 11; e <= 16; e++) step(0, 1, 0);
      for (int e = 17; e <= 30; e++) step(0, 1, 1);
      for (int e = 31; e <= 45; e++) step(0, 0, 0);
      check("both strobes", strobe_edges.size(), 0);
      check("both err count", err_edges.size(), 2);
      check("both err edge 1", err_at(0), 7);
      check("both err edge 2", err_at(1), 23);
      check("both cnt", entry_cnt, 2);

      // clr with the counter at 3 of 4, button held through clr release.
      mark();
      for (int e = 1; e <= 5; e++) step(0, 1, 0);
      step(1, 1, 0);
      check("clr mid-debounce strobes", strobe_edges.size(), 0);
      check("clr mid-debounce cnt", entry_cnt, 0);
      mark();
      for (int e = 1; e <= 10; e++) step(0, 1, 0);
      for (int e = 11; e <= 20; e++) step(0, 0, 0);
      check("held through clr edge", edge_at(0), 7);
      check("held through clr strobes", strobe_edges.size(), 1);
      check("held through clr cnt", entry_cnt, 1);

      // Long hold of btn_one for 40 cycles.
      step(1, 0, 0);
      step(1, 0, 0);
      mark();
      for (int e = 1; e <= 40; e++) step(0, 1, 0);
      for (int e = 41; e <= 55; e++) step(0, 0, 0);
`ifdef SEQ_AUTOREPEAT_EN
      check("hold strobes", strobe_edges.size(), 4);
      check("hold strobe 1", edge_at(0), 7);
      check("hold strobe 2", edge_at(1), 17);
      check("hold strobe 3", edge_at(2), 27);
      check("hold strobe 4", edge_at(3), 37);
      check("hold cnt", entry_cnt, 4);
`else
      check("hold strobes", strobe_edges.size(), 1);
      check("hold strobe 1", edge_at(0), 7);
      check("hold cnt", entry_cnt, 1);
`endif
      check("hold din", din, 1);

      // 256 accepted presses wrap the counter to zero.
      step(1, 0, 0);
      step(1, 0, 0);
      mark();
      for (int p = 0; p < 256; p++) begin
         for (int e = 0; e < 8; e++) step(0, 1, 0);
         for (int e = 0; e < 9; e++) step(0, 0, 0);
         if (p == 254) check("cnt after 255 presses", entry_cnt, 255);
      end
      check("wrap strobes", strobe_edges.size(), 256);
      check("wrap cnt", entry_cnt, 0);
      check("wrap errs", err_edges.size(), 0);

      check("din changed without strobe", din_glitch, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
